// File: rtl/period_reference_averager.sv
// Moving-average period reference for the counter-delayed trigger: filters last_counter
// changes, rejects out-of-range periods and averages the last 2^LOG2_DEPTH accepted ones.
module period_reference_averager #(
  parameter int COUNTER_WIDTH = 32,
  parameter int LOG2_DEPTH    = 3,
  parameter int REJECT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     trigger_armed,
  input  logic [COUNTER_WIDTH-1:0] last_counter,
  input  logic [COUNTER_WIDTH-1:0] period_min,
  input  logic [COUNTER_WIDTH-1:0] period_max,
  output logic [COUNTER_WIDTH-1:0] reference_counter,
  output logic                     reference_valid,
  output logic [LOG2_DEPTH:0]      sample_count,
  output logic [REJECT_WIDTH-1:0]  rejected_count
);
  localparam int DEPTH  = 1 << LOG2_DEPTH;
  localparam int SW     = COUNTER_WIDTH + LOG2_DEPTH;
  localparam int STAGES = 1;
  localparam logic [LOG2_DEPTH:0] FULL = (LOG2_DEPTH+1)'(DEPTH);

  logic flush;
  logic [COUNTER_WIDTH-1:0] prev;
  logic armed_d, skip;
  logic evt, fall, discard, in_range, take, reject;

  logic [STAGES:0]                    vld_pipe;
  logic [STAGES:0][COUNTER_WIDTH-1:0] v_pipe;

  logic [DEPTH-1:0][COUNTER_WIDTH-1:0] window;
  logic [LOG2_DEPTH-1:0]               wptr;
  logic [SW-1:0]                       sum;

  assign flush = !enable || clear;

  // The first change after the trigger disarms is the partial armed period; drop it.
  always_comb begin
    evt      = (last_counter != prev) && (last_counter != '0) && !trigger_armed;
    fall     = armed_d && !trigger_armed;
    discard  = evt && (skip || fall);
    in_range = (last_counter >= period_min) && (last_counter <= period_max);
    take     = evt && !discard && in_range;
    reject   = evt && !discard && !in_range;
  end

  // Stage 1: detect and classify
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      prev           <= '0;
      armed_d        <= 1'b0;
      skip           <= 1'b0;
      rejected_count <= '0;
      vld_pipe       <= '0;
      v_pipe         <= '0;
    end else if (flush) begin
      prev           <= '0;
      armed_d        <= 1'b0;
      skip           <= 1'b0;
      rejected_count <= '0;
      vld_pipe       <= '0;
      v_pipe         <= '0;
    end else begin
      prev    <= last_counter;
      armed_d <= trigger_armed;
      if (discard)   skip <= 1'b0;
      else if (fall) skip <= 1'b1;
      if (reject && rejected_count != '1)
        rejected_count <= rejected_count + REJECT_WIDTH'(1);
      vld_pipe <= {vld_pipe[STAGES-1:0], take};
      v_pipe   <= {v_pipe[STAGES-1:0], last_counter};
    end
  end

  // Stage 2: window/sum update; stage 3: publish reference
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      window            <= '0;
      wptr              <= '0;
      sum               <= '0;
      sample_count      <= '0;
      reference_counter <= '0;
      reference_valid   <= 1'b0;
    end else if (flush) begin
      window            <= '0;
      wptr              <= '0;
      sum               <= '0;
      sample_count      <= '0;
      reference_counter <= '0;
      reference_valid   <= 1'b0;
    end else begin
      if (vld_pipe[0]) begin
        // The evicted slot is always part of sum, so the subtraction cannot underflow.
        sum          <= sum + SW'(v_pipe[0]) - SW'(window[wptr]);
        window[wptr] <= v_pipe[0];
        wptr         <= wptr + LOG2_DEPTH'(1);
        if (sample_count != FULL)
          sample_count <= sample_count + (LOG2_DEPTH+1)'(1);
      end
      if (vld_pipe[STAGES]) begin
        if (sample_count == FULL) begin
          reference_counter <= sum[SW-1:LOG2_DEPTH];
          reference_valid   <= 1'b1;
        end else begin
          reference_counter <= v_pipe[STAGES];
        end
      end
    end
  end
endmodule

// File: tb/tb_period_reference_averager.sv
// Randomized + directed bench for period_reference_averager with a queue-based reference model.
module tb_period_reference_averager;
  localparam int CW = 32;
  localparam int L2 = 3;
  localparam int RW = 16;
  localparam int D  = 1 << L2;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic          trigger_armed = 1'b0;
  logic [CW-1:0] last_counter = '0;
  logic [CW-1:0] period_min = '0;
  logic [CW-1:0] period_max = '0;
  logic [CW-1:0] reference_counter;
  logic          reference_valid;
  logic [L2:0]   sample_count;
  logic [RW-1:0] rejected_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  period_reference_averager #(.COUNTER_WIDTH(CW), .LOG2_DEPTH(L2), .REJECT_WIDTH(RW)) dut (
    .clk(clk), .aresetn(aresetn), .enable(enable), .clear(clear),
    .trigger_armed(trigger_armed), .last_counter(last_counter),
    .period_min(period_min), .period_max(period_max),
    .reference_counter(reference_counter), .reference_valid(reference_valid),
    .sample_count(sample_count), .rejected_count(rejected_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [CW-1:0] hist[$];      // most recent D accepted values already in the window
  int            n_acc;
  int            m_rej;
  logic          p1_vld, p2_vld;
  logic [CW-1:0] p1_v;
  logic [CW-1:0] m_prev, m_ref;
  logic          m_armed_d, m_skip, m_valid;

  task automatic m_flush();
    hist.delete();
    n_acc = 0; m_rej = 0;
    p1_vld = 0; p2_vld = 0; p1_v = '0;
    m_prev = '0; m_ref = '0;
    m_armed_d = 0; m_skip = 0; m_valid = 0;
  endtask

  task automatic m_step();
    logic ev, fall;
    longint unsigned s;
    if (!aresetn || !enable || clear) m_flush();
    else begin
      if (p2_vld) begin
        if (n_acc >= D) begin
          s = 0;
          foreach (hist[i]) s += longint'(hist[i]);
          m_ref   = CW'(s >> L2);
          m_valid = 1;
        end else m_ref = hist[hist.size()-1];
      end
      p2_vld = p1_vld;
      if (p1_vld) begin
        hist.push_back(p1_v);
        n_acc++;
        if (hist.size() > D) void'(hist.pop_front());
      end
      ev   = (last_counter != m_prev) && (last_counter != 0) && !trigger_armed;
      fall = m_armed_d && !trigger_armed;
      p1_vld = 0;
      if (ev && (m_skip || fall)) m_skip = 0;
      else if (ev) begin
        if (last_counter >= period_min && last_counter <= period_max) begin
          p1_vld = 1; p1_v = last_counter;
        end else if (m_rej < 65535) m_rej++;
      end else if (fall) m_skip = 1;
      m_prev    = last_counter;
      m_armed_d = trigger_armed;
    end
  endtask

  initial begin
    m_flush();
    forever begin
      @(posedge clk or negedge aresetn);
      m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("model_ref", reference_counter, m_ref);
      chk("model_valid", reference_valid, m_valid);
      chk("model_count", sample_count, (n_acc > D) ? D : n_acc);
      chk("model_rej", rejected_count, m_rej);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 0 between values makes repeated periods register as fresh changes
  task automatic present(input logic [CW-1:0] v, input int hold);
    last_counter = '0;
    tick();
    last_counter = v;
    repeat (hold) tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    last_counter = '0;
    tick();
    clear = 1'b0;
  endtask

  logic [CW-1:0] fill_vals [7] = '{1000, 1002, 998, 1000, 1001, 999, 1000};

  initial begin
    int r;
    repeat (3) tick();
    chk("reset_ref", reference_counter, 0);
    chk("reset_valid", reference_valid, 0);
    chk("reset_count", sample_count, 0);
    chk("reset_rej", rejected_count, 0);
    aresetn = 1'b1;
    enable = 1'b1;
    period_min = 100;
    period_max = 10000;
    tick();

    // Fill to 8 samples, watch valid rise two edges after the 8th change
    foreach (fill_vals[i]) present(fill_vals[i], 20);
    last_counter = '0; tick();
    last_counter = 1000;
    tick(); tick();
    chk("t1_valid_k1", reference_valid, 0);
    chk("t1_count_k1", sample_count, 8);
    tick();
    chk("t1_valid_k2", reference_valid, 1);
    chk("t1_ref", reference_counter, 1000);
    repeat (18) tick();

    // Partial window reports latest sample
    do_clear();
    present(500, 5); present(600, 5); present(700, 5);
    chk("t2_ref", reference_counter, 700);
    chk("t2_valid", reference_valid, 0);
    chk("t2_count", sample_count, 3);

    // Rejection and saturation
    do_clear();
    repeat (8) present(1000, 3);
    chk("t3_full_ref", reference_counter, 1000);
    present(50000, 4);
    chk("t3_rej1", rejected_count, 1);
    chk("t3_ref_hold", reference_counter, 1000);
    for (int i = 0; i < 70000; i++) begin
      last_counter = (i % 2 == 0) ? 32'd50001 : 32'd50000;
      tick();
    end
    tick();
    chk("t3_rej_sat", rejected_count, 65535);
    chk("t3_ref_sat", reference_counter, 1000);

    // Armed freeze and post-arm skip
    trigger_armed = 1'b1;
    tick();
    for (int i = 0; i < 500; i++) begin
      last_counter = last_counter + 1;
      tick();
    end
    chk("t4_frozen", reference_counter, 1000);
    trigger_armed = 1'b0;
    tick();
    present(1200, 4);
    chk("t4_skip_ref", reference_counter, 1000);
    chk("t4_skip_count", sample_count, 8);
    present(1008, 4);
    chk("t4_avg", reference_counter, 1001);

    // Clear beats a simultaneous change
    clear = 1'b1;
    last_counter = 1500;
    tick();
    clear = 1'b0;
    chk("t5_count", sample_count, 0);
    chk("t5_ref", reference_counter, 0);
    chk("t5_valid", reference_valid, 0);
    last_counter = '0;
    repeat (3) tick();
    chk("t5_count_later", sample_count, 0);

    // Async reset with a sample in flight
    present(1000, 2); present(1001, 2);
    last_counter = '0; tick();
    last_counter = 900;
    tick();
    #2 aresetn = 1'b0;
    #1;
    chk("t6_ref_async", reference_counter, 0);
    chk("t6_count_async", sample_count, 0);
    chk("t6_valid_async", reference_valid, 0);
    last_counter = '0;
    tick(); tick();
    #2 aresetn = 1'b1;
    tick();
    present(800, 4);
    chk("t6_ref", reference_counter, 800);
    chk("t6_count", sample_count, 1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) begin
        case ($urandom_range(0, 3))
          0: begin period_min = 1000; period_max = 5000; end
          1: begin period_min = '0; period_max = '1; end
          2: begin period_min = 5000; period_max = 1000; end
          default: begin
            period_min = $urandom_range(1, 100000);
            period_max = period_min + $urandom_range(0, 2000);
          end
        endcase
      end
      r = $urandom_range(0, 99);
      if (r < 50) begin
        case ($urandom_range(0, 7))
          0: last_counter = '0;
          1: last_counter = period_min;
          2: last_counter = period_max;
          3: last_counter = period_min - 1;
          4: last_counter = period_max + 1;
          5: last_counter = $urandom();
          6: last_counter = 1000 + $urandom_range(0, 4000);
          default: last_counter = '1;
        endcase
      end
      if ($urandom_range(0, 19) == 0) trigger_armed = ~trigger_armed;
      clear  = ($urandom_range(0, 99) == 0);
      enable = ($urandom_range(0, 99) != 0);
      tick();
    end
    clear = 1'b0;
    enable = 1'b1;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/period_reference_averager.md
Name: period_reference_averager

Overview:
- Sits directly upstream of the counter-delayed trigger.
- Consumes that block's last_counter and trigger_armed outputs.
- Produces the reference_counter input as a moving average of the last 2^LOG2_DEPTH accepted period measurements.
- Rejects out-of-range periods, and ignores the continuously running counter value presented while the trigger is armed.

Parameters:
- COUNTER_WIDTH, 32: width of last_counter, period limits and reference_counter.
- LOG2_DEPTH, 3: log2 of the averaging window; 3 gives 8 entries; legal range 1..6.
- REJECT_WIDTH, 16: width of the saturating reject counter.

Ports:
- clk  in  1  system clock
- aresetn  in  1  asynchronous active-low reset
- enable  in  1  block enable; low clears all state
- clear  in  1  synchronous flush of window, sum and counters
- trigger_armed  in  1  arming status from the downstream trigger
- last_counter  in  COUNTER_WIDTH  last full period count from the downstream trigger
- period_min  in  COUNTER_WIDTH  smallest acceptable period (inclusive)
- period_max  in  COUNTER_WIDTH  largest acceptable period (inclusive)
- reference_counter  out  COUNTER_WIDTH  averaged period, to the downstream reference_counter input
- reference_valid  out  1  high once the window is full
- sample_count  out  LOG2_DEPTH+1  accepted samples in window, saturates at 2^LOG2_DEPTH
- rejected_count  out  REJECT_WIDTH  out-of-range samples seen, saturating

Behaviour:
- Reset (aresetn low, asynchronous):
  - All outputs go to 0: reference_counter, reference_valid, sample_count, rejected_count.
  - Window RAM, write pointer, running sum, prev register and skip flag also clear.
- enable low or clear high: same clearing, applied synchronously on the next edge.
  - clear beats any simultaneous sample event.
- prev register: loads last_counter every enabled cycle, including while armed.
- Stage 1, detect (edge k): event = (last_counter != prev) && (last_counter != 0) && !trigger_armed.
  - Armed-exit guard: on the falling edge of trigger_armed, set skip.
  - The first event after that edge is discarded, clears skip, and touches neither counter.
  - If trigger_armed rises again while skip is set, skip stays set.
  - A non-skipped event is accepted when period_min <= last_counter <= period_max, compared unsigned.
  - Otherwise rejected_count increments, saturating at all-ones.
  - If period_min > period_max, every event is rejected.
- Stage 2, update (edge k+1): for an accepted value v:
  - sum <= sum + v - window[wptr]; window[wptr] <= v; wptr increments modulo 2^LOG2_DEPTH.
  - sample_count increments until it saturates.
  - sum is COUNTER_WIDTH+LOG2_DEPTH bits wide, so it never overflows.
  - Unfilled slots hold 0.
- Stage 3, output (edge k+2):
  - If sample_count == 2^LOG2_DEPTH: reference_counter <= sum >> LOG2_DEPTH, truncated (floor), and reference_valid <= 1.
  - Otherwise reference_counter <= the most recent accepted v, and reference_valid stays 0.
- Latency: last_counter change sampled at edge k → reference_counter updated after edge k+2.
  - Back-to-back accepted samples on consecutive cycles are supported at one per cycle with no loss.
- Outputs hold their value between events.
  - Armed periods therefore present a frozen reference, which the downstream trigger requires.
- Wrap-around:
  - wptr wraps silently.
  - last_counter wrapping from max to a small value is treated as an ordinary change and goes through the range check.
- Reset mid-pipeline: in-flight samples are dropped; no partial sum update survives.

Test Plan:
1. Reset, enable=1, limits [100,10000]. Drive last_counter through 1000,1002,998,1000,1001,999,1000,1000, each held 20 cycles → reference_valid rises 2 cycles after the 8th change; reference_counter = 1000; sample_count = 8.
2. Mid fill, after 3 accepted samples (500,600,700) → reference_counter = 700, reference_valid = 0, sample_count = 3.
3. Full window of 1000s, then one sample of 50000 with period_max = 10000 → rejected_count = 1; reference_counter stays 1000. Repeat 70000 times → rejected_count saturates at 65535.
4. Armed freeze:
   - Assert trigger_armed and increment last_counter every cycle for 500 cycles → reference_counter unchanged.
   - Deassert, then present 1200 → it is skipped.
   - Then present 1008 → new average = (7·1000+1008)>>3 = 1001.
5. Same-cycle clear and a valid change → no sample recorded; sample_count = 0; reference_counter = 0.
6. Assert aresetn low asynchronously mid-stage-2 → all outputs 0 immediately without waiting for a clock. After release, the first sample 800 yields reference_counter = 800 with sample_count = 1.
